// File: rtl/melody_sequencer_if.sv
// Host/tone-generator side bundle for melody_sequencer: pattern writes,
// transport controls, and the registered playback outputs.
interface melody_sequencer_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [8:0] wr_data;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] note;
  logic       hush;
  logic       busy;
  logic [3:0] step;
  logic       done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop,
    input  note, hush, busy, step, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop,
    output note, hush, busy, step, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a 16-entry note/rest/duration pattern on the tone generator, with a
// silent articulation gap closing every non-rest step.
module melody_sequencer #(
  parameter int unsigned BEAT_CYCLES = 6_250_000,
  parameter int unsigned GAP_CYCLES  = 500_000
) (
  input logic               clk,
  input logic               rst_n,
  melody_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

  state_t      state, state_next;
  logic [8:0]  mem [16];
  logic [27:0] cnt, cnt_next;
  logic [3:0]  note_q, note_next;
  logic [3:0]  step_q, step_next;
  logic        hush_q, hush_next;
  logic        busy_q, busy_next;
  logic        done_q, done_next;

  logic [8:0]  cur_entry, nxt_entry, first_entry;
  logic [3:0]  step_inc;
  logic [31:0] cnt_wide, beat_span, play_last, gap_last;
  logic        song_end, restart_ok, advance;

  assign step_inc    = step_q + 4'd1;
  assign cur_entry   = mem[step_q];
  assign nxt_entry   = mem[step_inc];
  assign first_entry = mem[0];

  // Step length is computed at 32 bits so dur*BEAT_CYCLES never truncates.
  assign cnt_wide   = {4'b0, cnt};
  assign beat_span  = 32'(cur_entry[7:4]) * BEAT_CYCLES;
  assign play_last  = cur_entry[8] ? beat_span - 32'd1
                                   : beat_span - GAP_CYCLES - 32'd1;
  assign gap_last   = GAP_CYCLES - 32'd1;
  assign song_end   = (step_q == 4'd15) || (nxt_entry[7:4] == 4'd0);
  assign restart_ok = bus.loop && (first_entry[7:4] != 4'd0);

  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      note_q <= '0;
      step_q <= '0;
      hush_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      note_q <= note_next;
      step_q <= step_next;
      hush_q <= hush_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 28'd1;
    note_next  = note_q;
    step_next  = step_q;
    hush_next  = hush_q;
    advance    = 1'b0;

    case (state)
      IDLE: begin
        hush_next = 1'b1;
        cnt_next  = '0;
        if (bus.start && !bus.stop) begin
          if (first_entry[7:4] == 4'd0) begin
            state_next = DONE;
          end else begin
            state_next = PLAY;
            step_next  = '0;
            note_next  = first_entry[3:0];
            hush_next  = first_entry[8];
          end
        end
      end
      PLAY: begin
        if (cnt_wide == play_last) begin
          if (cur_entry[8]) begin
            advance = 1'b1;
          end else begin
            state_next = GAP;
            hush_next  = 1'b1;
            cnt_next   = '0;
          end
        end
      end
      GAP: begin
        if (cnt_wide == gap_last) begin
          advance = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        hush_next  = 1'b1;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        hush_next  = 1'b1;
        cnt_next   = '0;
      end
    endcase

    // Step transitions reload note/hush from the next entry so outputs stay registered.
    if (advance) begin
      cnt_next = '0;
      if (!song_end) begin
        state_next = PLAY;
        step_next  = step_inc;
        note_next  = nxt_entry[3:0];
        hush_next  = nxt_entry[8];
      end else if (restart_ok) begin
        state_next = PLAY;
        step_next  = '0;
        note_next  = first_entry[3:0];
        hush_next  = first_entry[8];
      end else begin
        state_next = DONE;
        hush_next  = 1'b1;
      end
    end

    if (bus.stop) begin
      state_next = IDLE;
      hush_next  = 1'b1;
      cnt_next   = '0;
    end

    done_next = (state_next == DONE);
    busy_next = (state_next == PLAY) || (state_next == GAP);
  end

  assign bus.note = note_q;
  assign bus.hush = hush_q;
  assign bus.busy = busy_q;
  assign bus.step = step_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed and randomized playback checks for melody_sequencer against a
// per-cycle trace built from the pattern contents.
module tb_melody_sequencer;
  localparam int unsigned BEAT = 10;
  localparam int unsigned GAP  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  melody_sequencer_if bus ();

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] note;
    logic       hush;
    logic       busy;
    logic [3:0] step;
    logic       done;
    bit         full;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  ref_mem [16];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    ref_mem[a]  = d;
  endtask

  function automatic logic [8:0] ent(input bit r, input int unsigned d, input int unsigned n);
    return {r, 4'(d), 4'(n)};
  endfunction

  // One pass of the song: each entry contributes dur*BEAT cycles; non-rest
  // entries are silent for their final GAP cycles.
  function automatic void add_pass();
    for (int unsigned s = 0; s < 16; s++) begin
      int unsigned d;
      d = ref_mem[s][7:4];
      if (d == 0) break;
      for (int unsigned c = 0; c < d * BEAT; c++) begin
        exp_t e;
        e.note = ref_mem[s][3:0];
        e.busy = 1'b1;
        e.done = 1'b0;
        e.step = 4'(s);
        e.hush = ref_mem[s][8] || (c >= d * BEAT - GAP);
        e.full = 1'b1;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void add_done();
    exp_t e;
    e.note = '0;
    e.step = '0;
    e.hush = 1'b1;
    e.busy = 1'b0;
    e.done = 1'b1;
    e.full = 1'b0;
    exp_q.push_back(e);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
    chk({tag, ".hush"}, 32'(bus.hush), 32'd1);
  endtask

  task automatic run_trace(input string tag, input int drop_loop_at, input bit spam);
    bus.start = 1'b1;
    foreach (exp_q[i]) begin
      if (i == drop_loop_at) bus.loop = 1'b0;
      tick();
      bus.start = 1'b0;
      chk($sformatf("%s[%0d].busy", tag, i), 32'(bus.busy), 32'(exp_q[i].busy));
      chk($sformatf("%s[%0d].done", tag, i), 32'(bus.done), 32'(exp_q[i].done));
      chk($sformatf("%s[%0d].hush", tag, i), 32'(bus.hush), 32'(exp_q[i].hush));
      if (exp_q[i].full) begin
        chk($sformatf("%s[%0d].note", tag, i), 32'(bus.note), 32'(exp_q[i].note));
        chk($sformatf("%s[%0d].step", tag, i), 32'(bus.step), 32'(exp_q[i].step));
      end
      bus.wr_en   = spam && exp_q[i].busy;
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 9'($urandom);
    end
    bus.wr_en = 1'b0;
    tick();
    check_idle({tag, ".after"});
    exp_q.delete();
  endtask

  initial begin
    int n1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop    = 1'b0;

    tick();
    tick();
    chk("rst.note", 32'(bus.note), 32'd0);
    chk("rst.step", 32'(bus.step), 32'd0);
    check_idle("rst");
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      check_idle("idle");
      chk("idle.step", 32'(bus.step), 32'd0);
    end
    for (int unsigned a = 0; a < 16; a++) wr(4'(a), '0);

    // Two-note song, then the same song with loop on for one extra pass.
    wr(0, ent(0, 1, 3));
    wr(1, ent(0, 2, 7));
    wr(2, ent(0, 0, 0));
    add_pass(); add_done();
    run_trace("song2", -1, 1'b0);

    bus.loop = 1'b1;
    add_pass(); n1 = exp_q.size(); add_pass(); add_done();
    run_trace("loop", n1 + 1, 1'b0);

    // Rest entry: no gap phase.
    wr(0, ent(1, 1, 5));
    wr(1, ent(0, 0, 0));
    add_pass(); add_done();
    run_trace("rest", -1, 1'b0);

    // Writes while busy must not alter the pattern.
    wr(0, ent(0, 1, 3));
    wr(1, ent(0, 2, 7));
    wr(2, ent(0, 0, 0));
    add_pass(); add_done();
    run_trace("spam", -1, 1'b1);
    add_pass(); add_done();
    run_trace("replay", -1, 1'b0);

    // Stop together with start mid-note.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int unsigned k = 0; k < 4; k++) tick();
    chk("stop.pre.busy", 32'(bus.busy), 32'd1);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    check_idle("stop");
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check_idle("stop.hold");
    end

    // Reset mid-song clears step/note but keeps the pattern.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int unsigned k = 0; k < 13; k++) tick();
    chk("rstmid.pre.step", 32'(bus.step), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("rstmid");
    chk("rstmid.step", 32'(bus.step), 32'd0);
    chk("rstmid.note", 32'(bus.note), 32'd0);
    add_pass(); add_done();
    run_trace("postrst", -1, 1'b0);

    // Full 16-entry song with no end marker.
    for (int unsigned a = 0; a < 16; a++) wr(4'(a), ent(0, 1, $urandom_range(0, 15)));
    add_pass(); add_done();
    run_trace("full16", -1, 1'b0);

    // Entry 0 is an end marker: immediate done, never busy.
    wr(0, ent(0, 0, 9));
    add_pass(); add_done();
    run_trace("empty", -1, 1'b0);

    // Randomized short songs.
    for (int unsigned r = 0; r < 6; r++) begin
      int unsigned len;
      len = $urandom_range(1, 5);
      for (int unsigned s = 0; s < len; s++)
        wr(4'(s), ent(1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(0, 15)));
      wr(4'(len), ent(0, 0, 0));
      add_pass(); add_done();
      run_trace($sformatf("rand%0d", r), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored sequence of notes on the piano tone generator by driving its 4-bit `note` select and `hush` inputs. A 16-entry pattern memory, written by the host, holds note, rest flag and duration per step. The block sits between the host/control logic and the tone generator. It also inserts a short articulation gap between consecutive notes so that repeated notes are audible as separate notes.

## Interface
- `BEAT_CYCLES`, default 6_250_000: clock cycles per beat; must be greater than `GAP_CYCLES`.
- `GAP_CYCLES`, default 500_000: silent cycles at the end of each non-rest step; must be at least 1.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `wr_en` input, 1 bit: pattern write strobe; ignored while `busy`=1.
- `wr_addr` input, 4 bits: pattern entry index.
- `wr_data` input, 9 bits: entry format is [8]=rest, [7:4]=duration in beats, [3:0]=note code.
- `start` input, 1 bit: begin playback at entry 0; sampled only in IDLE.
- `stop` input, 1 bit: abort playback.
- `loop` input, 1 bit: restart at entry 0 at end of song instead of finishing.
- `note` output, 4 bits: note code to the tone generator.
- `hush` output, 1 bit: 1 silences the tone generator.
- `busy` output, 1 bit: 1 in the PLAY and GAP states.
- `step` output, 4 bits: index of the entry currently playing.
- `done` output, 1 bit: one-cycle pulse on normal song completion.

## Operation
- Pattern memory is a 16x9 register array, read combinationally at `step`.
  - Reset does not clear it.
  - A write takes effect on the clock edge where `wr_en`=1 and `busy`=0.
- An entry with duration 0 is an end-of-song marker. Advancing past entry 15 also ends the song.
- States: IDLE, PLAY, GAP, DONE.
- IDLE: outputs `hush`=1, `busy`=0.
  - `start`=1 and `stop`=0 -> go to PLAY with `step`=0 and the cycle counter cleared.
  - If entry 0 has duration 0, go to DONE instead.
- PLAY: `note` = entry.note, `hush` = entry.rest.
  - Non-rest entry: stays dur*BEAT_CYCLES - GAP_CYCLES cycles, then -> GAP.
  - Rest entry: stays dur*BEAT_CYCLES cycles, then advances.
- GAP: `hush`=1 and `note` holds its value. Stays GAP_CYCLES cycles, then advances.
- Advance sequence:
  - `step` increments (4-bit).
  - If the new step would be 16 or the new entry has duration 0, the song ends:
    - `loop`=1 and entry 0 duration is not 0 -> `step`=0, go to PLAY.
    - Otherwise -> DONE.
  - Otherwise -> PLAY with the new step.
- DONE: lasts exactly one cycle with `done`=1, `hush`=1, `busy`=0, then -> IDLE.
- `stop`=1 in any state -> IDLE on the next edge, `hush`=1, no `done` pulse. `stop` wins over a simultaneous `start`.
- `start` while busy is ignored. `loop` is sampled only at end of song.
- Duration counter: 28-bit cycle counter, compared against dur*BEAT_CYCLES computed at full width with no truncation.

## Timing
- Reset values (apply on the edge with `rst_n`=0, whatever the state): state=IDLE, `note`=0, `hush`=1, `busy`=0, `step`=0, `done`=0, counter=0.
- `start` high at edge t -> from cycle t+1: `busy`=1, `step`=0, `note`/`hush` taken from entry 0.
- A non-rest step of d beats holds `hush`=0 for exactly d*BEAT_CYCLES - GAP_CYCLES cycles, then `hush`=1 for exactly GAP_CYCLES cycles.
- Total cycles per step are exactly d*BEAT_CYCLES. There are no idle cycles between steps.
- The cycle after the last step ends shows `done`=1. The following cycle is IDLE.
- `stop` at edge t -> `busy`=0 and `hush`=1 from cycle t+1.
- `rst_n` low mid-song behaves like `stop`, and also resets `step` and the counter.
- All outputs are registered. None depend combinationally on inputs.

## Test plan
All scenarios use BEAT_CYCLES=10 and GAP_CYCLES=2.

- Reset, then hold idle 5 cycles -> `hush`=1, `busy`=0, `done`=0, `step`=0 throughout.
- Write entries {rest0,dur1,note3}, {rest0,dur2,note7}, {dur0} and pulse `start`:
  - `note`=3 with `hush`=0 for 8 cycles, then `hush`=1 for 2 cycles.
  - `note`=7 with `hush`=0 for 18 cycles, then `hush`=1 for 2 cycles.
  - Then `done`=1 for 1 cycle, then IDLE.
- Entry 0 = {rest1,dur1,note5}, entry 1 = {dur0} -> `hush`=1 for 10 cycles with no gap phase, then a `done` pulse.
- Same two-note song with `loop`=1 -> after step 1 the next cycle is `step`=0, `note`=3, `hush`=0, and there is no `done` pulse. Dropping `loop` before the second pass -> `done` after the second pass.
- Mid-note `stop` together with `start` -> IDLE next cycle with `hush`=1 and no `done` pulse. `wr_en` while busy leaves memory unchanged (check by reading back through playback).
- All 16 entries with dur1 and no end marker -> 160 cycles with `step` going 0..15, then a `done` pulse. Entry 0 with dur 0 plus `start` -> `done` at t+1 and `busy` never 1.
